riscv32ima_mem_arbiter: RTL and testbench

Parametrised N-channel memory arbiter merging several core-side memory ports (instruction fetch, data LSU, optional debug/DMA) onto one downstream synchronous-SRAM-style port using the core's ncs/nwe/addr/wdata/wmask/rdata/stall protocol. It sits between `riscv32ima_core` and a single unified memory, replacing separate i-/d-memories. It adds grant locking under stall, per-channel read-data return routing and selectable fairness.

---
 rtl/riscv32ima_pkg.sv | 22 ++
 rtl/riscv32ima_arb_pick.sv | 41 ++++
 rtl/riscv32ima_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_riscv32ima_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv32ima_pkg.sv
// Shared definitions for the riscv32ima memory subsystem.
// Holds default bus widths, channel index typing and channel role constants
// used by the memory arbiter and its pick logic.
package riscv32ima_pkg;

   localparam int unsigned DEF_NUM_CH     = 2;
   localparam int unsigned DEF_ADDR_WIDTH = 32;
   localparam int unsigned DEF_DATA_WIDTH = 64;

   // Generic channel index, wide enough for any practical channel count
   localparam int unsigned CH_IDX_MAX_W = 8;
   typedef logic [CH_IDX_MAX_W-1:0] ch_idx_t;

   localparam ch_idx_t CH_FETCH = ch_idx_t'(0);
   localparam ch_idx_t CH_LSU   = ch_idx_t'(1);

   // Next channel index with wrap from n-1 back to 0
   function automatic int unsigned ch_wrap_inc(input int unsigned idx, input int unsigned n);
      return ((idx + 1) >= n) ? 0 : (idx + 1);
   endfunction

endpackage

// File: rtl/riscv32ima_arb_pick.sv
// Combinational channel picker.
// Scans the request vector starting at i_start, ascending with wrap, and
// returns the first requester as a one-hot grant plus its index. Tying
// i_start to 0 gives fixed priority (lowest index wins).
// Ports:
//   i_req    request vector, one bit per channel
//   i_start  first channel examined
//   o_gnt    one-hot grant (all zero when nobody requests)
//   o_idx    index of granted channel (0 when nobody requests)
module riscv32ima_arb_pick
   import riscv32ima_pkg::*;
#(
   parameter  int unsigned NUM_CH = DEF_NUM_CH,
   localparam int unsigned CH_W   = $clog2(NUM_CH)
)(
   input  logic [NUM_CH-1:0] i_req,
   input  logic [CH_W-1:0]   i_start,
   output logic [NUM_CH-1:0] o_gnt,
   output logic [CH_W-1:0]   o_idx
);

   int unsigned w_cand;
   logic        w_found;

   // Rotating first-match search
   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_cand  = 0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         w_cand = (32'(i_start) + k) % NUM_CH;
         if (!w_found && i_req[CH_W'(w_cand)]) begin
            w_found                = 1'b1;
            o_gnt[CH_W'(w_cand)]   = 1'b1;
            o_idx                  = CH_W'(w_cand);
         end
      end
   end

endmodule

// File: rtl/riscv32ima_mem_arbiter.sv
// N-channel memory arbiter merging core-side SRAM-style ports (fetch, LSU,
// optional debug/DMA) onto one downstream port.
// Build option: define RISCV32IMA_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority with channel 0 (fetch) highest.
// Ports:
//   clk, nrst                   clock, async active-low reset
//   s_ncs/s_nwe/s_addr/s_wdata/s_wmask   per-channel requests (slice i = channel i)
//   s_rdata/s_stall             per-channel read data return and stall
//   m_ncs/m_nwe/m_addr/m_wdata/m_wmask   downstream request (combinational from grant)
//   m_rdata/m_stall             downstream read data (1 cycle after accept) and stall
module riscv32ima_mem_arbiter
   import riscv32ima_pkg::*;
#(
   parameter  int unsigned NUM_CH     = DEF_NUM_CH,
   parameter  int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   localparam int unsigned CH_W       = $clog2(NUM_CH)
)(
   input  logic                         clk,
   input  logic                         nrst,
   input  logic [NUM_CH-1:0]            s_ncs,
   input  logic [NUM_CH-1:0]            s_nwe,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] s_addr,
   input  logic [NUM_CH*DATA_WIDTH-1:0] s_wdata,
   input  logic [NUM_CH*DATA_WIDTH-1:0] s_wmask,
   output logic [NUM_CH*DATA_WIDTH-1:0] s_rdata,
   output logic [NUM_CH-1:0]            s_stall,
   output logic                         m_ncs,
   output logic                         m_nwe,
   output logic [ADDR_WIDTH-1:0]        m_addr,
   output logic [DATA_WIDTH-1:0]        m_wdata,
   output logic [DATA_WIDTH-1:0]        m_wmask,
   input  logic [DATA_WIDTH-1:0]        m_rdata,
   input  logic                         m_stall
);

   logic [NUM_CH-1:0] w_req;
   logic [CH_W-1:0]   w_start;
   logic [NUM_CH-1:0] w_pick_gnt;
   logic [CH_W-1:0]   w_pick_idx;
   logic [NUM_CH-1:0] w_lock_oh;
   logic [NUM_CH-1:0] w_gnt_oh;
   logic [CH_W-1:0]   w_gnt_idx;
   logic              w_gnt_vld;
   logic              w_accept;

   logic              r_lock_vld;
   logic [CH_W-1:0]   r_lock_ch;
   logic              r_rd_vld;
   logic [CH_W-1:0]   r_rd_ch;

   assign w_req = ~s_ncs;

`ifdef RISCV32IMA_ARB_RR_EN
   logic [CH_W-1:0] r_rr_ptr;
   assign w_start = r_rr_ptr;
`else
   assign w_start = '0;
`endif

   riscv32ima_arb_pick #(
      .NUM_CH (NUM_CH)
   ) u_pick (
      .i_req   (w_req),
      .i_start (w_start),
      .o_gnt   (w_pick_gnt),
      .o_idx   (w_pick_idx)
   );

   // A locked channel keeps the grant regardless of other requesters
   always_comb begin
      w_lock_oh = '0;
      for (int unsigned i = 0; i < NUM_CH; i++)
         w_lock_oh[i] = (r_lock_ch == CH_W'(i));
      w_gnt_oh = r_lock_vld ? (w_lock_oh & w_req) : w_pick_gnt;
   end

   assign w_gnt_idx = r_lock_vld ? r_lock_ch : w_pick_idx;
   assign w_gnt_vld = |w_gnt_oh;
   assign w_accept  = w_gnt_vld & ~m_stall;

   // Downstream mux from the granted channel; idle values when nobody is granted
   always_comb begin
      m_ncs   = 1'b1;
      m_nwe   = 1'b1;
      m_addr  = '0;
      m_wdata = '0;
      m_wmask = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (w_gnt_oh[i]) begin
            m_ncs   = 1'b0;
            m_nwe   = s_nwe[i];
            m_addr  = s_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            m_wdata = s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            m_wmask = s_wmask[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Requesters stall unless granted and the downstream is free
   assign s_stall = w_req & ~(w_gnt_oh & {NUM_CH{~m_stall}});

   // Read data routed only to the channel whose read was accepted last cycle
   always_comb begin
      s_rdata = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (r_rd_vld && (r_rd_ch == CH_W'(i)))
            s_rdata[i*DATA_WIDTH +: DATA_WIDTH] = m_rdata;
      end
   end

   // Grant lock under stall and read-return tracking
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_lock_vld <= 1'b0;
         r_lock_ch  <= '0;
         r_rd_vld   <= 1'b0;
         r_rd_ch    <= '0;
      end else begin
         r_lock_vld <= w_gnt_vld & m_stall;
         if (w_gnt_vld && m_stall)
            r_lock_ch <= w_gnt_idx;
         r_rd_vld <= w_accept & m_nwe;
         if (w_accept)
            r_rd_ch <= w_gnt_idx;
      end
   end

`ifdef RISCV32IMA_ARB_RR_EN
   // Round-robin pointer moves past each accepted channel
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         r_rr_ptr <= '0;
      else if (w_accept)
         r_rr_ptr <= CH_W'(ch_wrap_inc(32'(w_gnt_idx), NUM_CH));
   end
`endif

endmodule

// File: tb/tb_riscv32ima_mem_arbiter.sv
// Self-checking bench for riscv32ima_mem_arbiter (2 channels).
module tb_riscv32ima_mem_arbiter;

   localparam int unsigned NCH = 2;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 64;
   localparam logic [63:0] WD0 = 64'h0000_0000_0000_00A0;
   localparam logic [63:0] WM0 = 64'h0000_0000_0000_00FF;
   localparam logic [63:0] WM1 = 64'hFFFF_FFFF_FFFF_FFFF;

   logic              clk = 1'b0;
   logic              nrst;
   logic [NCH-1:0]    s_ncs, s_nwe, s_stall;
   logic [NCH*AW-1:0] s_addr;
   logic [NCH*DW-1:0] s_wdata, s_wmask, s_rdata;
   logic              m_ncs, m_nwe, m_stall;
   logic [AW-1:0]     m_addr;
   logic [DW-1:0]     m_wdata, m_wmask, m_rdata;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   riscv32ima_mem_arbiter #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .nrst(nrst),
      .s_ncs(s_ncs), .s_nwe(s_nwe), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wmask(s_wmask), .s_rdata(s_rdata), .s_stall(s_stall),
      .m_ncs(m_ncs), .m_nwe(m_nwe), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_wmask(m_wmask), .m_rdata(m_rdata), .m_stall(m_stall)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Spec rules: a stalled grant keeps its channel; otherwise the first
   // requester in priority order (rotating from last winner+1 in RR mode).
   int md_lock, md_lock_ch, md_rd_vld, md_rd_ch, md_ptr;
   logic [NCH-1:0] last_est;

   function automatic bit bitof(input logic [NCH-1:0] v, input int c);
      return ((v >> c) & NCH'(1)) != '0;
   endfunction

   task automatic mdl_reset();
      md_lock = 0; md_lock_ch = 0; md_rd_vld = 0; md_rd_ch = 0; md_ptr = 0;
      last_est = '0;
   endtask

   function automatic int mdl_grant(input logic [NCH-1:0] req);
      if (md_lock != 0) return bitof(req, md_lock_ch) ? md_lock_ch : -1;
      for (int k = 0; k < NCH; k++) begin
         int c;
         c = (md_ptr + k) % NCH;
         if (bitof(req, c)) return c;
      end
      return -1;
   endfunction

   task automatic mdl_update(input int g);
      bit acc;
      acc = (g >= 0) && !m_stall;
      md_lock = ((g >= 0) && m_stall) ? 1 : 0;
      if (md_lock != 0) md_lock_ch = g;
      md_rd_vld = (acc && bitof(s_nwe, g)) ? 1 : 0;
      if (acc) md_rd_ch = g;
`ifdef RISCV32IMA_ARB_RR_EN
      if (acc) md_ptr = (g + 1) % NCH;
`endif
   endtask

   task automatic check_model(input int g);
      int gi;
      logic [NCH-1:0] req, est;
      logic [63:0] erd;
      req = ~s_ncs;
      gi  = (g < 0) ? 0 : g;
      chk("m_ncs",   64'(m_ncs),   (g < 0) ? 64'd1 : 64'd0);
      chk("m_nwe",   64'(m_nwe),   (g < 0) ? 64'd1 : 64'(bitof(s_nwe, gi)));
      chk("m_addr",  64'(m_addr),  (g < 0) ? 64'd0 : 64'(s_addr[gi*AW +: AW]));
      chk("m_wdata", m_wdata,      (g < 0) ? 64'd0 : s_wdata[gi*DW +: DW]);
      chk("m_wmask", m_wmask,      (g < 0) ? 64'd0 : s_wmask[gi*DW +: DW]);
      est = '0;
      for (int c = 0; c < NCH; c++)
         if (bitof(req, c) && (c != g || m_stall)) est = est | (NCH'(1) << c);
      chk("s_stall", 64'(s_stall), 64'(est));
      last_est = est;
      for (int c = 0; c < NCH; c++) begin
         erd = (md_rd_vld != 0 && md_rd_ch == c) ? m_rdata : 64'd0;
         chk($sformatf("s_rdata%0d", c), s_rdata[c*DW +: DW], erd);
      end
   endtask

   // One cycle: inputs already driven just after a rising edge
   task automatic step();
      int g;
      if (!nrst) mdl_reset();
      g = mdl_grant(~s_ncs);
      @(negedge clk);
      check_model(g);
      @(posedge clk);
      if (!nrst) mdl_reset(); else mdl_update(g);
      cyc++;
      #1;
   endtask

   task automatic set_idle();
      s_ncs = '1; s_nwe = '1; s_addr = '0; s_wdata = '0; s_wmask = '0;
      m_stall = 1'b0; m_rdata = '0;
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      set_idle();
      @(posedge clk);
      @(posedge clk);
      #1 nrst = 1'b1;
      mdl_reset();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [1:0]  ncs, nwe;
      logic [31:0] a0, a1;
      logic [63:0] wd1;
      logic        mst;
      logic [63:0] rdata;
      logic        e_ncs, e_nwe;
      logic [31:0] e_addr;
      logic [63:0] e_wd, e_wm;
      logic [1:0]  e_stall;
      logic [63:0] e_rd0, e_rd1;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic [63:0] ch_ncs, ch_nwe;
      logic [31:0] ch_addr [NCH];
      logic [63:0] ch_wd [NCH], ch_wm [NCH];

      nrst = 1'b0;
      set_idle();
      mdl_reset();

      // reset state
      @(negedge clk);
      chk("rst_m_ncs", 64'(m_ncs), 64'd1);
      chk("rst_s_stall", 64'(s_stall), 64'd0);
      chk("rst_s_rdata", s_rdata[63:0] | s_rdata[127:64], 64'd0);
      @(posedge clk);
      #1 nrst = 1'b1;

`ifndef RISCV32IMA_ARB_RR_EN
      tbl[0]  = '{2'b10, 2'b11, 32'h100, 32'h0,   64'h0,  1'b0, 64'h0,    1'b0, 1'b1, 32'h100, WD0,    WM0,   2'b00, 64'h0,    64'h0};
      tbl[1]  = '{2'b11, 2'b11, 32'h0,   32'h0,   64'h0,  1'b0, 64'hDEAD, 1'b1, 1'b1, 32'h0,   64'h0,  64'h0, 2'b00, 64'hDEAD, 64'h0};
      tbl[2]  = '{2'b00, 2'b11, 32'h200, 32'h300, 64'h0,  1'b0, 64'h1111, 1'b0, 1'b1, 32'h200, WD0,    WM0,   2'b10, 64'h0,    64'h0};
      tbl[3]  = '{2'b01, 2'b11, 32'h200, 32'h300, 64'h0,  1'b0, 64'h2222, 1'b0, 1'b1, 32'h300, 64'h0,  WM1,   2'b00, 64'h2222, 64'h0};
      tbl[4]  = '{2'b11, 2'b11, 32'h0,   32'h0,   64'h0,  1'b0, 64'h3333, 1'b1, 1'b1, 32'h0,   64'h0,  64'h0, 2'b00, 64'h0,    64'h3333};
      tbl[5]  = '{2'b01, 2'b11, 32'h0,   32'h400, 64'h0,  1'b1, 64'h4444, 1'b0, 1'b1, 32'h400, 64'h0,  WM1,   2'b10, 64'h0,    64'h0};
      tbl[6]  = '{2'b00, 2'b11, 32'h500, 32'h400, 64'h0,  1'b1, 64'h4444, 1'b0, 1'b1, 32'h400, 64'h0,  WM1,   2'b11, 64'h0,    64'h0};
      tbl[7]  = '{2'b00, 2'b11, 32'h500, 32'h400, 64'h0,  1'b1, 64'h4444, 1'b0, 1'b1, 32'h400, 64'h0,  WM1,   2'b11, 64'h0,    64'h0};
      tbl[8]  = '{2'b00, 2'b11, 32'h500, 32'h400, 64'h0,  1'b0, 64'h4444, 1'b0, 1'b1, 32'h400, 64'h0,  WM1,   2'b01, 64'h0,    64'h0};
      tbl[9]  = '{2'b10, 2'b11, 32'h500, 32'h0,   64'h0,  1'b0, 64'h5555, 1'b0, 1'b1, 32'h500, WD0,    WM0,   2'b00, 64'h0,    64'h5555};
      tbl[10] = '{2'b01, 2'b01, 32'h0,   32'h40,  64'h55, 1'b0, 64'h6666, 1'b0, 1'b0, 32'h40,  64'h55, WM1,   2'b00, 64'h6666, 64'h0};
      tbl[11] = '{2'b11, 2'b11, 32'h0,   32'h0,   64'h0,  1'b0, 64'h7777, 1'b1, 1'b1, 32'h0,   64'h0,  64'h0, 2'b00, 64'h0,    64'h0};

      for (int i = 0; i < 12; i++) begin
         s_ncs   = tbl[i].ncs;
         s_nwe   = tbl[i].nwe;
         s_addr  = {tbl[i].a1, tbl[i].a0};
         s_wdata = {tbl[i].wd1, WD0};
         s_wmask = {WM1, WM0};
         m_stall = tbl[i].mst;
         m_rdata = tbl[i].rdata;
         @(negedge clk);
         chk($sformatf("t%0d_m_ncs", i),   64'(m_ncs),   64'(tbl[i].e_ncs));
         chk($sformatf("t%0d_m_nwe", i),   64'(m_nwe),   64'(tbl[i].e_nwe));
         chk($sformatf("t%0d_m_addr", i),  64'(m_addr),  64'(tbl[i].e_addr));
         chk($sformatf("t%0d_m_wdata", i), m_wdata,      tbl[i].e_wd);
         chk($sformatf("t%0d_m_wmask", i), m_wmask,      tbl[i].e_wm);
         chk($sformatf("t%0d_s_stall", i), 64'(s_stall), 64'(tbl[i].e_stall));
         chk($sformatf("t%0d_rd0", i),     s_rdata[63:0],   tbl[i].e_rd0);
         chk($sformatf("t%0d_rd1", i),     s_rdata[127:64], tbl[i].e_rd1);
         @(posedge clk);
         cyc++;
         #1;
      end
`else
      // Round-robin: both channels requesting continuously alternate
      do_reset();
      s_ncs = 2'b00; s_addr = {32'h20, 32'h10};
      for (int k = 0; k < 5; k++) begin
         if (k == 4) s_ncs = 2'b11;
         m_rdata = 64'hA000 + 64'(k);
         @(negedge clk);
         if (k < 4) chk($sformatf("rr%0d_addr", k), 64'(m_addr), (k % 2 == 0) ? 64'h10 : 64'h20);
         if (k >= 1) begin
            chk($sformatf("rr%0d_rd_hit", k),  s_rdata[((k-1)%2)*DW +: DW], 64'hA000 + 64'(k));
            chk($sformatf("rr%0d_rd_miss", k), s_rdata[(k%2)*DW +: DW],     64'h0);
         end
         @(posedge clk);
         cyc++;
         #1;
      end
`endif

      // Async reset while a read return is pending
      do_reset();
      s_ncs = 2'b01; s_addr = {32'h80, 32'h0};
      @(negedge clk);
      chk("seq_a_addr", 64'(m_addr), 64'h80);
      @(posedge clk);
      #1 set_idle(); m_rdata = 64'h9999;
      #1 chk("seq_rd_pre", s_rdata[127:64], 64'h9999);
      nrst = 1'b0;
      #1 chk("seq_rd_rst1", s_rdata[127:64], 64'h0);
      chk("seq_rd_rst0", s_rdata[63:0], 64'h0);
      @(posedge clk);
      #1 nrst = 1'b1;

      // Async reset while ch1 holds a stall lock
      s_ncs = 2'b01; s_addr = {32'h84, 32'h0}; m_stall = 1'b1;
      @(posedge clk);
      #1 s_ncs = 2'b00; s_addr = {32'h84, 32'h88};
      #1 chk("seq_lock_addr", 64'(m_addr), 64'h84);
      chk("seq_lock_stall", 64'(s_stall), 64'h3);
      m_stall = 1'b0; nrst = 1'b0;
      #1 chk("seq_rst_addr", 64'(m_addr), 64'h88);
      chk("seq_rst_stall", 64'(s_stall), 64'h2);
      chk("seq_rst_rdata", s_rdata[63:0] | s_rdata[127:64], 64'h0);
      @(posedge clk);
      #1 nrst = 1'b1;
      #1 chk("seq_rel_addr", 64'(m_addr), 64'h88);
      set_idle();
      #1 chk("seq_rel_ncs", 64'(m_ncs), 64'd1);
      @(posedge clk);
      #1;

      // Randomized traffic against the reference model
      do_reset();
      ch_ncs = '1; ch_nwe = '1;
      for (int c = 0; c < NCH; c++) begin
         ch_addr[c] = '0; ch_wd[c] = '0; ch_wm[c] = '0;
      end
      for (int n = 0; n < 1500; n++) begin
         nrst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         for (int c = 0; c < NCH; c++) begin
            // a stalled requester keeps its request unchanged
            if (!bitof(last_est, c)) begin
               ch_ncs[c]  = ($urandom_range(0, 99) < 60) ? 1'b0 : 1'b1;
               ch_nwe[c]  = 1'($urandom_range(0, 1));
               ch_addr[c] = $urandom;
               ch_wd[c]   = {$urandom, $urandom};
               ch_wm[c]   = {$urandom, $urandom};
            end
            s_ncs[c] = ch_ncs[c];
            s_nwe[c] = ch_nwe[c];
            s_addr[c*AW +: AW]  = ch_addr[c];
            s_wdata[c*DW +: DW] = ch_wd[c];
            s_wmask[c*DW +: DW] = ch_wm[c];
         end
         m_stall = ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0;
         m_rdata = {$urandom, $urandom};
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
